range_hit_monitor: RTL and testbench
====================================

Name: range_hit_monitor

Overview:
- Downstream consumer of the 4-bit range detector's z output. z=1 means the input value is in the window 6..9.
- Samples z on a valid strobe and counts total in-window samples.
- Tracks runs of consecutive in-window samples and raises a registered alarm once a run reaches RUN_LEN.
- Produces a one-cycle rise pulse on each out-of-window to in-window transition, for logging and test-bench checking.

Parameters:
- RUN_LEN, 3: consecutive valid z=1 samples needed to enter ALARM. Legal range 1..15.
- CNT_W, 8: width of the total hit counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- z  in  1  range detector output (1 = value in 6..9).
- zv  in  1  sample valid; z is ignored when zv=0.
- clr  in  1  synchronous clear of counters and FSM.
- alarm  out  1  high while FSM is in ALARM.
- rise  out  1  one-cycle pulse on a 0->1 transition of valid z.
- run_cnt  out  4  length of the current consecutive-hit run, saturating at 15.
- hit_cnt  out  CNT_W  total valid z=1 samples, saturating at all-ones.
- state  out  2  FSM state: IDLE=00, RUN=01, ALARM=10. 11 is unused.

Behaviour:
- All outputs are registered. A sample taken at edge k is reflected on the outputs after edge k, so latency is 1 clock.
- Reset (rst=1 at an edge) sets:
  - state=IDLE
  - alarm=0, rise=0
  - run_cnt=0, hit_cnt=0
  - internal prev_z=0
- rst has priority over clr, and clr has priority over the sample.
- clr=1 at an edge:
  - Same result as reset.
  - The sample presented in that cycle is discarded: no count, no rise.
- zv=0 at an edge:
  - state, run_cnt, hit_cnt and prev_z hold.
  - rise=0.
- Valid sample (zv=1, no rst or clr):
  - hit_cnt increments by 1 if z=1, holding at 2^CNT_W-1 once saturated.
  - rise = z & ~prev_z; then prev_z is updated to z.
- FSM transitions are evaluated only on valid samples:
  - IDLE, z=1: run_cnt=1. Next state is ALARM if RUN_LEN==1, else RUN.
  - IDLE, z=0: stay in IDLE, run_cnt=0.
  - RUN, z=1: run_cnt+1. Go to ALARM when run_cnt+1==RUN_LEN, else stay in RUN.
  - RUN, z=0: go to IDLE, run_cnt=0.
  - ALARM, z=1: stay in ALARM; run_cnt increments, saturating at 15.
  - ALARM, z=0: go to IDLE, run_cnt=0.
- alarm = (next state == ALARM), registered, so it rises on the same edge the FSM enters ALARM.
- Any zv=0 gap inside a run does not break the run.
- Illegal state 11 must recover to IDLE on the next edge, with alarm=0.

Test Plan:
- Reset: rst=1 for 2 cycles with random z/zv → all outputs 0, state=00.
- Run to alarm:
  - Stimulus: RUN_LEN=3; valid z sequence 0,1,1,1,1,0.
  - Required: rise=1 only after the 2nd sample.
  - Required: state goes 00,01,01,10,10,00; alarm=1 after the 4th and 5th samples.
  - Required: run_cnt goes 0,1,2,3,4,0; final hit_cnt=4.
- Gap tolerance: valid z=1, zv=0 for 5 cycles, then valid z=1,1 → alarm=1 after the 3rd valid sample; rise pulses once only.
- Broken run: valid z=1,1,0,1,1 → never enters ALARM; rise pulses twice; hit_cnt=4; state ends at 01.
- Saturation and clear:
  - Stimulus: CNT_W=4; 20 valid z=1 samples.
  - Required: hit_cnt=15 and run_cnt=15, both held.
  - Stimulus: then clr=1 together with zv=1, z=1.
  - Required: all outputs 0 next cycle; that sample is not counted.
- Reset mid-alarm: in ALARM, assert rst → next cycle alarm=0, state=00, run_cnt=0. A following valid z=1 produces rise=1, because prev_z was cleared by the reset.

Source files
------------

// File: rtl/range_hit_monitor.sv
// range_hit_monitor: counts valid in-window samples, tracks hit runs and raises a registered alarm.
module range_hit_monitor #(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z,
    input  logic             zv,
    input  logic             clr,
    output logic             alarm,
    output logic             rise,
    output logic [3:0]       run_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, ALARM = 2'b10} state_t;
    state_t           state_q, state_d;
    logic [3:0]       run_d;
    logic [CNT_W-1:0] hit_d;
    logic             prev_z, prev_d, rise_d;
    assign state = state_q;
    always_comb begin
        state_d = state_q;
        run_d   = run_cnt;
        hit_d   = hit_cnt;
        prev_d  = prev_z;
        rise_d  = 1'b0;
        if (zv) begin
            hit_d  = (z && !(&hit_cnt)) ? hit_cnt + 1'b1 : hit_cnt;
            rise_d = z & ~prev_z;
            prev_d = z;
        end
        case (state_q)
            IDLE: if (zv) begin
                run_d   = z ? 4'd1 : 4'd0;
                state_d = !z ? IDLE : (RUN_LEN == 1) ? ALARM : RUN;
            end
            RUN: if (zv) begin
                run_d   = z ? run_cnt + 4'd1 : 4'd0;
                state_d = !z ? IDLE : (run_cnt + 4'd1 == 4'(RUN_LEN)) ? ALARM : RUN;
            end
            ALARM: if (zv) begin
                run_d   = !z ? 4'd0 : (&run_cnt) ? run_cnt : run_cnt + 4'd1;
                state_d = z ? ALARM : IDLE;
            end
            default: begin
                run_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q <= IDLE;
            alarm   <= 1'b0;
            rise    <= 1'b0;
            run_cnt <= '0;
            hit_cnt <= '0;
            prev_z  <= 1'b0;
        end else begin
            state_q <= state_d;
            alarm   <= (state_d == ALARM);
            rise    <= rise_d;
            run_cnt <= run_d;
            hit_cnt <= hit_d;
            prev_z  <= prev_d;
        end
    end
endmodule

// File: tb/tb_range_hit_monitor.sv
// tb_range_hit_monitor: directed and random stimulus checked against a run-length reference model.
module tb_range_hit_monitor;
    localparam int RUN_LEN = 3;
    localparam int CNT_W   = 4;
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             z = 1'b0;
    logic             zv = 1'b0;
    logic             clr = 1'b0;
    logic             alarm, rise;
    logic [3:0]       run_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic [1:0]       state;
    int               errors = 0;
    int               checks = 0;
    int               m_run = 0;
    int               m_hits = 0;
    bit               m_prev = 1'b0;
    bit               m_rise = 1'b0;
    range_hit_monitor #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .z(z), .zv(zv), .clr(clr),
        .alarm(alarm), .rise(rise), .run_cnt(run_cnt), .hit_cnt(hit_cnt), .state(state)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step(input bit s_rst, input bit s_clr, input bit s_zv, input bit s_z, input string tag);
        int max_cnt;
        max_cnt = (1 << CNT_W) - 1;
        rst = s_rst;
        clr = s_clr;
        zv  = s_zv;
        z   = s_z;
        @(posedge clk);
        if (s_rst || s_clr) begin
            m_run = 0; m_hits = 0; m_prev = 0; m_rise = 0;
        end else if (s_zv) begin
            m_rise = s_z && !m_prev;
            m_prev = s_z;
            if (s_z) begin
                m_run++;
                m_hits++;
            end else m_run = 0;
        end else m_rise = 0;
        #1;
        check({tag, ".alarm"}, int'(alarm), int'(m_run >= RUN_LEN));
        check({tag, ".rise"}, int'(rise), int'(m_rise));
        check({tag, ".state"}, int'(state), m_run == 0 ? 0 : (m_run >= RUN_LEN ? 2 : 1));
        check({tag, ".run_cnt"}, int'(run_cnt), m_run > 15 ? 15 : m_run);
        check({tag, ".hit_cnt"}, int'(hit_cnt), m_hits > max_cnt ? max_cnt : m_hits);
    endtask
    initial begin
        bit seq_run[6] = '{0, 1, 1, 1, 1, 0};
        bit seq_brk[5] = '{1, 1, 0, 1, 1};
        int rises;
        for (int i = 0; i < 2; i++) step(1, 0, 1'($urandom), 1'($urandom), "reset");
        rises = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, seq_run[i], "run_alarm");
            rises += int'(rise);
        end
        check("run_alarm.rises", rises, 1);
        check("run_alarm.final_hits", int'(hit_cnt), 4);
        step(0, 1, 0, 0, "clr1");
        rises = 0;
        step(0, 0, 1, 1, "gap");
        rises += int'(rise);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1'($urandom), "gap_hold");
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 1, "gap_resume");
            rises += int'(rise);
        end
        check("gap.alarm", int'(alarm), 1);
        check("gap.rises", rises, 1);
        step(0, 1, 0, 0, "clr2");
        rises = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, seq_brk[i], "broken");
            rises += int'(rise);
        end
        check("broken.rises", rises, 2);
        check("broken.hits", int'(hit_cnt), 4);
        check("broken.state", int'(state), 1);
        step(0, 1, 0, 0, "clr3");
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1, "sat");
        check("sat.hit_cnt", int'(hit_cnt), 15);
        check("sat.run_cnt", int'(run_cnt), 15);
        step(0, 1, 1, 1, "sat_clr");
        check("sat_clr.hit_cnt", int'(hit_cnt), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, "pre_rst");
        step(1, 0, 1, 1, "mid_rst");
        check("mid_rst.alarm", int'(alarm), 0);
        step(0, 0, 1, 1, "post_rst");
        check("post_rst.rise", int'(rise), 1);
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step(r == 0, r == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, "random");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
